vend_dispenser: RTL and testbench

//   Mechanism-side end of the vending controller's delivery interface. Accepts the
//   1-cycle product (X) and coin-return (Y) pulses, queues them, and drives the

---
 rtl/vend_dispenser_pkg.sv | 41 ++++
 rtl/vend_dispenser_if.sv | 31 +++
 rtl/vend_dispenser_timer.sv | 34 +++
 rtl/vend_dispenser.sv | 128 ++++++++++++
 tb/tb_vend_dispenser.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/vend_dispenser_pkg.sv
// ----------------------------------------------------------------------------
// vend_dispenser_pkg : shared state encodings, coin codes and sizing helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vend_dispenser_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MOTOR     = 3'd1,
        S_WAIT_DROP = 3'd2,
        S_COIN      = 3'd3,
        S_GAP       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    // Coin codes shared with the coin FSM; 2'b01 also decodes as "none".
    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_ONE  = 2'b10,
        COIN_TWO  = 2'b11
    } coin_code_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bits needed to hold (cycles - 1), the largest value the timer is loaded with.
    function automatic int timer_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vend_dispenser_if.sv
// ----------------------------------------------------------------------------
// vend_dispenser_if : request/sensor inputs and actuator/status outputs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface vend_dispenser_if;

    logic prdt;
    logic ret;
    logic prod_sensed;
    logic fault_clr;
    logic motor_on;
    logic sol_on;
    logic busy;
    logic fault;
    logic ovf;

    modport master (
        output prdt, ret, prod_sensed, fault_clr,
        input  motor_on, sol_on, busy, fault, ovf
    );

    modport slave (
        input  prdt, ret, prod_sensed, fault_clr,
        output motor_on, sol_on, busy, fault, ovf
    );

endinterface

`default_nettype wire

// File: rtl/vend_dispenser_timer.sv
// ----------------------------------------------------------------------------
// vend_dispenser_timer : loadable down-counter shared by all timed states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vend_dispenser_timer #(
    parameter int WIDTH = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             dec,
    output logic                  done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/vend_dispenser.sv
// ----------------------------------------------------------------------------
// vend_dispenser : queues product/coin-return pulses and sequences the actuators
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vend_dispenser
    import vend_dispenser_pkg::*;
#(
    parameter int MOTOR_CYCLES = 8,
    parameter int DROP_TIMEOUT = 16,
    parameter int SOL_CYCLES   = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int PEND_W       = 2
) (
    input  wire logic      clock,
    input  wire logic      reset,
    vend_dispenser_if.slave bus
);

    localparam int TMAX = max4(MOTOR_CYCLES, DROP_TIMEOUT, SOL_CYCLES, GAP_CYCLES);
    localparam int TW   = timer_width(TMAX);

    localparam logic [TW-1:0] MOTOR_LD = TW'(MOTOR_CYCLES - 1);
    localparam logic [TW-1:0] DROP_LD  = TW'(DROP_TIMEOUT - 1);
    localparam logic [TW-1:0] SOL_LD   = TW'(SOL_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);

    state_t              state, state_nxt;
    logic [PEND_W-1:0]   prdt_pend, ret_pend;
    logic [PEND_W-1:0]   prdt_pend_nxt, ret_pend_nxt;
    logic                prdt_lost, ret_lost;
    logic                prdt_dec, ret_dec;
    logic                t_load, t_dec, t_done;
    logic [TW-1:0]       t_val;
    logic                motor_q, sol_q, busy_q, fault_q, ovf_q;

    // Returns {lost, next_count}; a simultaneous increment and decrement cancel.
    function automatic logic [PEND_W:0] pend_step(input logic [PEND_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        logic              lost;
        logic [PEND_W-1:0] n;
        lost = 1'b0;
        n    = cnt;
        if (inc && !dec) begin
            if (&cnt) lost = 1'b1;
            else      n    = cnt + 1'b1;
        end else if (dec && !inc) begin
            n = cnt - 1'b1;
        end
        return {lost, n};
    endfunction

    vend_dispenser_timer #(.WIDTH(TW)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .done     (t_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (prdt_pend != '0)     state_nxt = S_MOTOR;
                else if (ret_pend != '0) state_nxt = S_COIN;
            end
            S_MOTOR:     if (t_done) state_nxt = S_WAIT_DROP;
            S_WAIT_DROP: begin
                if (bus.prod_sensed) state_nxt = S_GAP;
                else if (t_done)     state_nxt = S_FAULT;
            end
            S_COIN:      if (t_done) state_nxt = S_GAP;
            S_GAP:       if (t_done) state_nxt = S_IDLE;
            S_FAULT:     if (bus.fault_clr) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase

        // Every state change reloads the timer with the new state's duration.
        t_load = (state_nxt != state);
        t_dec  = !t_load;
        case (state_nxt)
            S_MOTOR:     t_val = MOTOR_LD;
            S_WAIT_DROP: t_val = DROP_LD;
            S_COIN:      t_val = SOL_LD;
            S_GAP:       t_val = GAP_LD;
            default:     t_val = '0;
        endcase

        prdt_dec = (state == S_WAIT_DROP) && bus.prod_sensed;
        ret_dec  = (state == S_IDLE) && (state_nxt == S_COIN);
        {prdt_lost, prdt_pend_nxt} = pend_step(prdt_pend, bus.prdt, prdt_dec);
        {ret_lost,  ret_pend_nxt}  = pend_step(ret_pend,  bus.ret,  ret_dec);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            prdt_pend <= '0;
            ret_pend  <= '0;
            motor_q   <= 1'b0;
            sol_q     <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            prdt_pend <= prdt_pend_nxt;
            ret_pend  <= ret_pend_nxt;
            motor_q   <= (state_nxt == S_MOTOR);
            sol_q     <= (state_nxt == S_COIN);
            fault_q   <= (state_nxt == S_FAULT);
            busy_q    <= (state_nxt != S_IDLE) || (prdt_pend_nxt != '0) || (ret_pend_nxt != '0);
            ovf_q     <= ovf_q | prdt_lost | ret_lost;
        end
    end

    assign bus.motor_on = motor_q;
    assign bus.sol_on   = sol_q;
    assign bus.busy     = busy_q;
    assign bus.fault    = fault_q;
    assign bus.ovf      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_dispenser.sv
// ----------------------------------------------------------------------------
// tb_vend_dispenser : directed self-checking bench for vend_dispenser
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vend_dispenser;
    import vend_dispenser_pkg::*;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    int   mcnt, scnt, overlap, last_m, first_s;
    logic [11:0] trace;

    vend_dispenser_if bus();

    vend_dispenser #(
        .MOTOR_CYCLES (8),
        .DROP_TIMEOUT (16),
        .SOL_CYCLES   (4),
        .GAP_CYCLES   (2),
        .PEND_W       (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic pulse(input logic p, input logic r);
        bus.prdt = p;
        bus.ret  = r;
        step();
        bus.prdt = 1'b0;
        bus.ret  = 1'b0;
    endtask

    // Steps n cycles tallying actuator activity; with sense set, the drop
    // sensor fires on the first cycle after the motor stops.
    task automatic track(input int n, input bit sense);
        logic prev_m;
        mcnt = 0; scnt = 0; overlap = 0; last_m = -1; first_s = 1000000;
        prev_m = bus.motor_on;
        for (int i = 0; i < n; i++) begin
            step();
            bus.prod_sensed = sense && prev_m && !bus.motor_on;
            if (bus.motor_on) begin mcnt++; last_m = i; end
            if (bus.sol_on) begin
                scnt++;
                if (i < first_s) first_s = i;
            end
            if (bus.motor_on && bus.sol_on) overlap++;
            prev_m = bus.motor_on;
        end
        bus.prod_sensed = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1;
        bus.prdt = 1'b0; bus.ret = 1'b0; bus.prod_sensed = 1'b0; bus.fault_clr = 1'b0;
        do_reset();

        check("rst_motor", bus.motor_on, 0);
        check("rst_sol",   bus.sol_on,   0);
        check("rst_busy",  bus.busy,     0);
        check("rst_fault", bus.fault,    0);
        check("rst_ovf",   bus.ovf,      0);

        // Single product, drop seen 3 clocks after motor stops
        pulse(1'b1, 1'b0);
        trace = '0;
        trace[0] = bus.motor_on;
        check("t1_busy_k1", bus.busy, 1);
        for (int k = 2; k <= 12; k++) begin
            step();
            trace[k-1] = bus.motor_on;
        end
        check("t1_motor_trace", trace, 12'h1FE);
        check("t1_state_wait", dut.state, S_WAIT_DROP);
        bus.prod_sensed = 1'b1;
        step();
        bus.prod_sensed = 1'b0;
        check("t1_state_gap", dut.state, S_GAP);
        check("t1_pend0",     dut.prdt_pend, 0);
        step();
        check("t1_busy_gap",  bus.busy, 1);
        step();
        check("t1_busy_idle", bus.busy, 0);
        check("t1_state_idle", dut.state, S_IDLE);

        // Product and coin requested together
        pulse(1'b1, 1'b1);
        track(40, 1'b1);
        check("t2_motor_cnt", mcnt, 8);
        check("t2_sol_cnt",   scnt, 4);
        check("t2_overlap",   overlap, 0);
        check("t2_order",     (first_s > last_m), 1);
        check("t2_busy_end",  bus.busy, 0);

        // Jam, coin returns queued during fault, then retry
        pulse(1'b1, 1'b0);
        repeat (24) step();
        check("t3_nofault_k25", bus.fault, 0);
        step();
        check("t3_fault_k26", bus.fault, 1);
        check("t3_motor_off", bus.motor_on, 0);
        pulse(1'b0, 1'b1);
        step();
        pulse(1'b0, 1'b1);
        check("t3_ret_pend", dut.ret_pend, 2);
        check("t3_prdt_pend", dut.prdt_pend, 1);
        check("t3_fault_hold", bus.fault, 1);
        check("t3_sol_off", bus.sol_on, 0);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        check("t3_fault_clr", bus.fault, 0);
        track(80, 1'b1);
        check("t3_motor_cnt", mcnt, 8);
        check("t3_sol_cnt",   scnt, 8);
        check("t3_overlap",   overlap, 0);
        check("t3_order",     (first_s > last_m), 1);
        check("t3_busy_end",  bus.busy, 0);
        check("t3_fault_end", bus.fault, 0);

        // Saturation: four more requests while the motor runs
        pulse(1'b1, 1'b0);
        step();
        check("t4_motor_on", bus.motor_on, 1);
        check("t4_ovf_pre",  bus.ovf, 0);
        bus.prdt = 1'b1;
        repeat (4) step();
        bus.prdt = 1'b0;
        check("t4_sat_pend", dut.prdt_pend, 3);
        check("t4_ovf",      bus.ovf, 1);
        check("t4_motor_still", bus.motor_on, 1);

        // Reset mid-MOTOR
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_motor_off", bus.motor_on, 0);
        check("t5_pend0",     dut.prdt_pend, 0);
        check("t5_state",     dut.state, S_IDLE);
        check("t5_ovf0",      bus.ovf, 0);
        check("t5_busy0",     bus.busy, 0);

        // Drop sensor outside WAIT_DROP is ignored
        bus.prod_sensed = 1'b1;
        step();
        bus.prod_sensed = 1'b0;
        check("t6_idle_state", dut.state, S_IDLE);
        check("t6_idle_busy",  bus.busy, 0);
        check("t6_idle_pend",  dut.prdt_pend, 0);
        pulse(1'b0, 1'b1);
        step();
        check("t6_sol_k2", bus.sol_on, 1);
        bus.prod_sensed = 1'b1;
        step();
        bus.prod_sensed = 1'b0;
        check("t6_sol_k3",   bus.sol_on, 1);
        check("t6_coin_st",  dut.state, S_COIN);
        check("t6_ret_pend", dut.ret_pend, 0);
        check("t6_prdt_pend", dut.prdt_pend, 0);
        step(); step();
        check("t6_sol_k5", bus.sol_on, 1);
        step();
        check("t6_sol_k6", bus.sol_on, 0);
        check("t6_gap_st", dut.state, S_GAP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
